// File: rtl/usrt_bus_ctrl.sv
// usrt_bus_ctrl: APB-style slave front-end for the USRT.
// Sequences each bus access (setup -> access -> optional TX wait -> response),
// decodes the 2-bit register address into status/config write, TX load and
// RX pop strobes, inserts wait states while the transmitter is busy, and owns
// the interrupt flag/enable register.
//
// Ports:
//   i_Pclk, i_Reset            clock, synchronous active-high reset
//   i_Psel, i_Enable, i_Pwrite bus control (setup/access phases)
//   i_Paddr, i_Data            register address, write data
//   o_Rdata, o_Ready, o_Slverr bus response (valid while o_Ready = 1)
//   i_Status                   status register value (addr 0 read)
//   i_Tx_Busy                  transmitter busy
//   i_Rx_Full, i_Rx_Data       receiver holds a byte / the byte
//   o_Cfg_Wr, o_Cfg_Data       status register write strobe and data
//   o_Tx_Start, o_Tx_Data      transmitter load strobe and held byte
//   o_Rx_Ack                   receiver pop strobe
//   o_Irq                      interrupt line
module usrt_bus_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = 5
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic       i_Psel,
    input  logic       i_Enable,
    input  logic       i_Pwrite,
    input  logic [1:0] i_Paddr,
    input  logic [7:0] i_Data,
    output logic [7:0] o_Rdata,
    output logic       o_Ready,
    output logic       o_Slverr,
    input  logic [7:0] i_Status,
    input  logic       i_Tx_Busy,
    input  logic       i_Rx_Full,
    input  logic [7:0] i_Rx_Data,
    output logic       o_Cfg_Wr,
    output logic [7:0] o_Cfg_Data,
    output logic       o_Tx_Start,
    output logic [7:0] o_Tx_Data,
    output logic       o_Rx_Ack,
    output logic       o_Irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TXWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [1:0]        flag, flag_nxt;
    logic [1:0]        en, en_nxt;
    logic [1:0]        flag_clr;
    logic [1:0]        flag_set;
    logic              rx_full_q, tx_busy_q;

    logic [7:0]        rdata_nxt, cfg_data_nxt, tx_data_nxt;
    logic              ready_nxt, slverr_nxt, cfg_wr_nxt, tx_start_nxt, rx_ack_nxt;

    // Next state, and the response/strobe values that become visible in RESP.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        en_nxt       = en;
        flag_clr     = 2'b00;
        rdata_nxt    = 8'h00;
        ready_nxt    = 1'b0;
        slverr_nxt   = 1'b0;
        cfg_wr_nxt   = 1'b0;
        cfg_data_nxt = o_Cfg_Data;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = o_Tx_Data;
        rx_ack_nxt   = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                // Only a genuine setup phase starts a transfer.
                if (i_Psel && !i_Enable) begin
                    state_nxt = ACCESS;
                end
            end

            ACCESS: begin
                if (!i_Psel) begin
                    state_nxt = IDLE;
                end else if (i_Enable) begin
                    if (i_Pwrite && (i_Paddr == 2'd1) && i_Tx_Busy) begin
                        state_nxt    = TXWAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else begin
                        state_nxt = RESP;
                        ready_nxt = 1'b1;
                        case ({i_Pwrite, i_Paddr})
                            3'b100: begin
                                cfg_wr_nxt   = 1'b1;
                                cfg_data_nxt = i_Data;
                            end
                            3'b000: rdata_nxt = i_Status;
                            3'b101: begin
                                tx_start_nxt = 1'b1;
                                tx_data_nxt  = i_Data;
                            end
                            3'b001: rdata_nxt = o_Tx_Data;
                            3'b010: begin
                                if (i_Rx_Full) begin
                                    rdata_nxt  = i_Rx_Data;
                                    rx_ack_nxt = 1'b1;
                                end else begin
                                    slverr_nxt = 1'b1;
                                end
                            end
                            3'b110: slverr_nxt = 1'b1;
                            3'b011: rdata_nxt = {2'b00, en, 2'b00, flag};
                            3'b111: begin
                                en_nxt   = i_Data[5:4];
                                flag_clr = i_Data[1:0];
                            end
                            default: ;
                        endcase
                    end
                end
            end

            TXWAIT: begin
                if (!i_Psel) begin
                    state_nxt = IDLE;
                end else if (!i_Tx_Busy) begin
                    state_nxt    = RESP;
                    ready_nxt    = 1'b1;
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = i_Data;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    // Transmitter never freed up: give up with an error.
                    state_nxt  = RESP;
                    ready_nxt  = 1'b1;
                    slverr_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            RESP: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase

        // flag0: rising edge of rx_full; flag1: falling edge of tx_busy. Set wins.
        flag_set = {~i_Tx_Busy & tx_busy_q, i_Rx_Full & ~rx_full_q};
        flag_nxt = (flag & ~flag_clr) | flag_set;
    end

    // State, IRQ bookkeeping and registered outputs.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            flag       <= 2'b00;
            en         <= 2'b00;
            rx_full_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            o_Rdata    <= 8'h00;
            o_Ready    <= 1'b0;
            o_Slverr   <= 1'b0;
            o_Cfg_Wr   <= 1'b0;
            o_Cfg_Data <= 8'h00;
            o_Tx_Start <= 1'b0;
            o_Tx_Data  <= 8'h00;
            o_Rx_Ack   <= 1'b0;
            o_Irq      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            flag       <= flag_nxt;
            en         <= en_nxt;
            rx_full_q  <= i_Rx_Full;
            tx_busy_q  <= i_Tx_Busy;
            o_Rdata    <= rdata_nxt;
            o_Ready    <= ready_nxt;
            o_Slverr   <= slverr_nxt;
            o_Cfg_Wr   <= cfg_wr_nxt;
            o_Cfg_Data <= cfg_data_nxt;
            o_Tx_Start <= tx_start_nxt;
            o_Tx_Data  <= tx_data_nxt;
            o_Rx_Ack   <= rx_ack_nxt;
            o_Irq      <= |(flag & en);
        end
    end

endmodule

// File: tb/tb_usrt_bus_ctrl.sv
// Directed testbench for usrt_bus_ctrl: bus transfers with hand-computed
// responses, strobe counts and latencies.
module tb_usrt_bus_ctrl;

    logic       r_Clock = 1'b0;
    logic       r_Reset = 1'b1;
    logic       psel = 1'b0, enable = 1'b0, pwrite = 1'b0;
    logic [1:0] paddr = 2'd0;
    logic [7:0] pdata = 8'h00;
    logic [7:0] status = 8'h00;
    logic       tx_busy = 1'b0, rx_full = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [7:0] rdata, cfg_data, tx_data;
    logic       ready, slverr, cfg_wr, tx_start, rx_ack, irq;

    int total = 0;
    int bad   = 0;

    // Per-transfer observations.
    int         n_rdy, n_cfg, n_tx, n_ack, lat, rdy_lat;
    logic [7:0] r_rdata, r_cfg_data, r_tx_data;
    logic       r_slverr;

    usrt_bus_ctrl #(.MAX_WAIT(16), .WAIT_W(5)) dut (
        .i_Pclk    (r_Clock),
        .i_Reset   (r_Reset),
        .i_Psel    (psel),
        .i_Enable  (enable),
        .i_Pwrite  (pwrite),
        .i_Paddr   (paddr),
        .i_Data    (pdata),
        .o_Rdata   (rdata),
        .o_Ready   (ready),
        .o_Slverr  (slverr),
        .i_Status  (status),
        .i_Tx_Busy (tx_busy),
        .i_Rx_Full (rx_full),
        .i_Rx_Data (rx_data),
        .o_Cfg_Wr  (cfg_wr),
        .o_Cfg_Data(cfg_data),
        .o_Tx_Start(tx_start),
        .o_Tx_Data (tx_data),
        .o_Rx_Ack  (rx_ack),
        .o_Irq     (irq)
    );

    always #5 r_Clock = ~r_Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge r_Clock);
        #1;
    endtask

    // One bus transfer over a fixed 24-cycle window. Event indices are loop
    // iterations (k=0 drives the access-phase edge); -1 disables an event.
    task automatic xfer(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                        input int drop_at, input int abort_at, input int rise_at,
                        input int reset_at);
        psel = 1'b1; enable = 1'b0; pwrite = wr; paddr = addr; pdata = data;
        step();
        enable = 1'b1;
        lat = 1; n_rdy = 0; n_cfg = 0; n_tx = 0; n_ack = 0; rdy_lat = -1;
        r_rdata = 8'hxx; r_slverr = 1'bx; r_cfg_data = 8'hxx; r_tx_data = 8'hxx;
        for (int k = 0; k < 24; k++) begin
            if (k == drop_at)  tx_busy = 1'b0;
            if (k == abort_at) begin psel = 1'b0; enable = 1'b0; end
            if (k == rise_at)  rx_full = 1'b1;
            if (k == reset_at) r_Reset = 1'b1;
            if (reset_at >= 0 && k == reset_at + 1) begin
                r_Reset = 1'b0; psel = 1'b0; enable = 1'b0;
            end
            step();
            lat++;
            if (cfg_wr)   n_cfg++;
            if (tx_start) n_tx++;
            if (rx_ack)   n_ack++;
            if (ready) begin
                n_rdy++;
                if (n_rdy == 1) begin
                    rdy_lat = lat; r_rdata = rdata; r_slverr = slverr;
                    r_cfg_data = cfg_data; r_tx_data = tx_data;
                end
                psel = 1'b0; enable = 1'b0;
            end
        end
        psel = 1'b0; enable = 1'b0;
    endtask

    initial begin
        step(); step();
        r_Reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_txdata", 32'(tx_data), 32'h00);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cfgwr", 32'(cfg_wr), 32'd0);

        // Config write, zero wait.
        xfer(1'b1, 2'd0, 8'h0D, -1, -1, -1, -1);
        check("cfg_lat", 32'(rdy_lat), 32'd2);
        check("cfg_nrdy", 32'(n_rdy), 32'd1);
        check("cfg_nwr", 32'(n_cfg), 32'd1);
        check("cfg_data", 32'(r_cfg_data), 32'h0D);
        check("cfg_slverr", 32'(r_slverr), 32'd0);

        // TX write stalled 5 wait cycles then busy drops.
        tx_busy = 1'b1; step();
        xfer(1'b1, 2'd1, 8'hA5, 5, -1, -1, -1);
        check("txw_lat", 32'(rdy_lat), 32'd7);
        check("txw_nrdy", 32'(n_rdy), 32'd1);
        check("txw_nstart", 32'(n_tx), 32'd1);
        check("txw_data", 32'(r_tx_data), 32'hA5);
        check("txw_slverr", 32'(r_slverr), 32'd0);
        xfer(1'b0, 2'd3, 8'h00, -1, -1, -1, -1);
        check("irq_flag1", 32'(r_rdata), 32'h02);
        xfer(1'b1, 2'd3, 8'h02, -1, -1, -1, -1);
        xfer(1'b0, 2'd3, 8'h00, -1, -1, -1, -1);
        check("irq_clr", 32'(r_rdata), 32'h00);

        // TX write times out with busy held.
        tx_busy = 1'b1; step();
        xfer(1'b1, 2'd1, 8'h3C, -1, -1, -1, -1);
        check("txto_lat", 32'(rdy_lat), 32'd18);
        check("txto_nrdy", 32'(n_rdy), 32'd1);
        check("txto_slverr", 32'(r_slverr), 32'd1);
        check("txto_nstart", 32'(n_tx), 32'd0);
        check("txto_data", 32'(tx_data), 32'hA5);
        tx_busy = 1'b0; step();
        xfer(1'b0, 2'd1, 8'h00, -1, -1, -1, -1);
        check("txrd_data", 32'(r_rdata), 32'hA5);
        xfer(1'b1, 2'd2, 8'h11, -1, -1, -1, -1);
        check("rxwr_slverr", 32'(r_slverr), 32'd1);

        // RX reads, empty then full.
        xfer(1'b0, 2'd2, 8'h00, -1, -1, -1, -1);
        check("rxe_rdata", 32'(r_rdata), 32'h00);
        check("rxe_slverr", 32'(r_slverr), 32'd1);
        check("rxe_nack", 32'(n_ack), 32'd0);
        rx_full = 1'b1; rx_data = 8'h5A; step();
        xfer(1'b0, 2'd2, 8'h00, -1, -1, -1, -1);
        check("rxf_rdata", 32'(r_rdata), 32'h5A);
        check("rxf_slverr", 32'(r_slverr), 32'd0);
        check("rxf_nack", 32'(n_ack), 32'd1);
        rx_full = 1'b0; step();

        // IRQ: clear everything, enable both, then rx_full rising edge.
        xfer(1'b1, 2'd3, 8'h03, -1, -1, -1, -1);
        xfer(1'b1, 2'd3, 8'h30, -1, -1, -1, -1);
        check("irq_off", 32'(irq), 32'd0);
        rx_full = 1'b1; step(); step();
        check("irq_on", 32'(irq), 32'd1);
        xfer(1'b0, 2'd3, 8'h00, -1, -1, -1, -1);
        check("irq_reg", 32'(r_rdata), 32'h31);
        rx_full = 1'b0; step();
        // W1C on flag0 in the same cycle as a new rising edge: set wins.
        xfer(1'b1, 2'd3, 8'h31, -1, -1, 0, -1);
        xfer(1'b0, 2'd3, 8'h00, -1, -1, -1, -1);
        check("irq_setwins", 32'(r_rdata), 32'h31);
        check("irq_hold", 32'(irq), 32'd1);
        rx_full = 1'b0; step();

        // Psel dropped during TXWAIT.
        tx_busy = 1'b1; step();
        xfer(1'b1, 2'd1, 8'h77, -1, 3, -1, -1);
        check("abt_nrdy", 32'(n_rdy), 32'd0);
        check("abt_nstart", 32'(n_tx), 32'd0);
        check("abt_data", 32'(tx_data), 32'hA5);
        tx_busy = 1'b0; step();

        // Reset during ACCESS.
        xfer(1'b1, 2'd0, 8'h44, -1, -1, -1, 0);
        check("rsa_nrdy", 32'(n_rdy), 32'd0);
        check("rsa_ncfg", 32'(n_cfg), 32'd0);
        check("rsa_txdata", 32'(tx_data), 32'h00);
        check("rsa_irq", 32'(irq), 32'd0);

        status = 8'h96;
        xfer(1'b0, 2'd0, 8'h00, -1, -1, -1, -1);
        check("st_lat", 32'(rdy_lat), 32'd2);
        check("st_rdata", 32'(r_rdata), 32'h96);
        check("st_slverr", 32'(r_slverr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usrt_bus_ctrl.md
Name: usrt_bus_ctrl

Overview:
- APB-style slave front-end that sequences every bus access to the USRT: it decodes a 2-bit register address and drives the status/config register write strobe, the transmitter load, and the receiver acknowledge.
- Inserts wait states while the transmitter is busy and flags bus errors.
- Holds a small interrupt flag/enable register and drives the single interrupt line.
- Sits between the bus master and the statusreg / tx / rx blocks.

Parameters:
MAX_WAIT, 16, maximum wait-state cycles a TX write may stall before it is aborted with an error (1..31)
WAIT_W, 5, width of the wait-state counter; must hold MAX_WAIT

Ports:
i_Pclk  in  1  clock; all logic is on the rising edge
i_Reset  in  1  synchronous, active-high reset
i_Psel  in  1  slave select
i_Enable  in  1  APB enable (access phase)
i_Pwrite  in  1  1 = write, 0 = read
i_Paddr  in  2  register address: 0 = CFG/STATUS, 1 = TXDATA, 2 = RXDATA, 3 = IRQ
i_Data  in  8  write data
o_Rdata  out  8  read data; valid while o_Ready = 1
o_Ready  out  1  transfer-complete pulse
o_Slverr  out  1  error response; valid with o_Ready
i_Status  in  8  current status register value
i_Tx_Busy  in  1  transmitter busy
i_Rx_Full  in  1  receiver holds an unread byte
i_Rx_Data  in  8  received byte
o_Cfg_Wr  out  1  one-cycle write strobe to the status register
o_Cfg_Data  out  8  config data; valid with o_Cfg_Wr
o_Tx_Start  out  1  one-cycle load strobe to the transmitter
o_Tx_Data  out  8  byte to transmit; holds the last byte written
o_Rx_Ack  out  1  one-cycle pop strobe to the receiver
o_Irq  out  1  interrupt, registered

Behaviour:
- Reset: state IDLE. All outputs 0, o_Rdata 0, o_Tx_Data 0. IRQ flags and enables 0. Wait counter 0. Reset mid-transfer aborts the transfer with no strobe and no o_Ready.
- FSM states: IDLE, ACCESS, TXWAIT, RESP.
  - IDLE -> ACCESS when i_Psel=1 and i_Enable=0 (setup phase). i_Enable=1 seen in IDLE without a prior setup is ignored.
  - ACCESS, in the cycle with i_Psel=1 and i_Enable=1:
    - If the access is a write to addr 1 and i_Tx_Busy=1: go to TXWAIT and load counter = 1.
    - Otherwise: execute the access and go to RESP.
  - TXWAIT:
    - i_Tx_Busy=0: execute the TX write and go to RESP.
    - Counter = MAX_WAIT with busy still high: go to RESP with error set and no o_Tx_Start.
    - Otherwise: increment the counter.
  - RESP: o_Ready=1 for exactly one cycle, together with o_Rdata, o_Slverr and the single-cycle side-effect strobe; then IDLE.
  - i_Psel=0 in ACCESS or TXWAIT: abort to IDLE, no strobes, no o_Ready.
- Latency: a zero-wait access completes two cycles after the setup cycle (setup N, access N+1, o_Ready in N+2). A stalled TX write adds one cycle per TXWAIT cycle.
- Execute rules:
  - Write addr 0: o_Cfg_Wr=1, o_Cfg_Data=i_Data.
  - Read addr 0: o_Rdata=i_Status.
  - Write addr 1: o_Tx_Start=1, o_Tx_Data=i_Data.
  - Read addr 1: o_Rdata=o_Tx_Data.
  - Read addr 2 with i_Rx_Full=1: o_Rdata=i_Rx_Data, o_Rx_Ack=1.
  - Read addr 2 with i_Rx_Full=0: o_Rdata=0, o_Slverr=1, no ack.
  - Write addr 2: o_Slverr=1, no side effect.
  - Read addr 3: o_Rdata = {2'b00, en[1:0], 2'b00, flag[1:0]}.
  - Write addr 3: en <= i_Data[5:4]; flag[k] cleared where i_Data[k]=1 (write-1-to-clear).
- IRQ flags:
  - flag0 sets on a rising edge of i_Rx_Full.
  - flag1 sets on a falling edge of i_Tx_Busy.
  - Edge detection uses a registered copy of each input, which resets to 0.
  - If a set and a clear hit the same cycle, set wins.
  - o_Irq = |(flag & en), registered (one cycle after the flag/enable change).
- Only one transfer is in flight at a time; a new setup phase is recognised only in IDLE.

Test Plan:
- Reset, then write addr 0 with 0x0D -> exactly one o_Cfg_Wr pulse with o_Cfg_Data=0x0D in the o_Ready cycle, 2 cycles after setup; o_Slverr=0.
- i_Tx_Busy=1, write addr 1 with 0xA5, drop busy after 5 cycles -> o_Tx_Start with o_Tx_Data=0xA5 one cycle after busy falls; o_Ready once; flag1 sets.
- i_Tx_Busy held high, write addr 1 with 0x3C -> o_Ready and o_Slverr=1 after MAX_WAIT=16 wait cycles; no o_Tx_Start; o_Tx_Data unchanged.
- Read addr 2 with i_Rx_Full=0 -> o_Rdata=0x00, o_Slverr=1. Then i_Rx_Full=1 and i_Rx_Data=0x5A -> o_Rdata=0x5A and one o_Rx_Ack pulse.
- Write addr 3 with 0x30, then raise i_Rx_Full -> flag0=1 and o_Irq=1. Write addr 3 with 0x31 on the same cycle as a new rising edge of i_Rx_Full -> flag0 stays 1 (set wins).
- i_Psel dropped during TXWAIT, and separately i_Reset asserted during ACCESS -> return to IDLE with no strobes and no o_Ready; the next normal read of addr 0 returns i_Status.
